// File: rtl/axi_wr_arb_pkg.sv
// Shared types for the AXI write-channel arbiter.
// Struct layouts describe the default configuration of the arbiter.
package axi_wr_arb_pkg;

    localparam int AXI_NUM_M  = 4;
    localparam int AXI_IDX_W  = $clog2(AXI_NUM_M);
    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   awid;
        logic [AXI_ADDR_W-1:0] awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
    } aw_pld_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
    } w_pld_t;

    typedef struct packed {
        logic [AXI_ID_W+AXI_IDX_W-1:0] bid;
        logic [1:0]                    bresp;
    } b_pld_t;

    localparam int AW_W = $bits(aw_pld_t);
    localparam int W_W  = $bits(w_pld_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_pick
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_M = AXI_NUM_M,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    int               j;
    logic [IDX_W-1:0] jw;

    // Walk from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        j       = 0;
        jw      = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            j  = (int'(ptr) + i) % NUM_M;
            jw = IDX_W'(j);
            if (req[jw]) begin
                gnt_idx = jw;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI write arbiter: AW grant held through the W burst,
// requester index prepended to AWID, B routed back by the upper ID bits.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_M  = AXI_NUM_M,
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    localparam int IDX_W = $clog2(NUM_M),
    localparam int AW_PW = ID_W + ADDR_W + 13,
    localparam int W_PW  = DATA_W + DATA_W / 8 + 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NUM_M-1:0]            s_aw_valid,
    output logic [NUM_M-1:0]            s_aw_ready,
    input  logic [NUM_M*AW_PW-1:0]      s_aw_pld,
    input  logic [NUM_M-1:0]            s_w_valid,
    output logic [NUM_M-1:0]            s_w_ready,
    input  logic [NUM_M*W_PW-1:0]       s_w_pld,
    output logic [NUM_M-1:0]            s_b_valid,
    input  logic [NUM_M-1:0]            s_b_ready,
    output logic [ID_W+1:0]             s_b_pld,
    output logic                        m_aw_valid,
    input  logic                        m_aw_ready,
    output logic [AW_PW+IDX_W-1:0]      m_aw_pld,
    output logic                        m_w_valid,
    input  logic                        m_w_ready,
    output logic [W_PW-1:0]             m_w_pld,
    input  logic                        m_b_valid,
    output logic                        m_b_ready,
    input  logic [ID_W+IDX_W+1:0]       m_b_pld
);

    state_e           state, state_n;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic [AW_PW-1:0] aw_sel;
    logic [W_PW-1:0]  w_sel;
    logic             aw_go;
    logic             w_go;
    logic             w_done;
    logic [IDX_W-1:0] b_idx;

    rr_pick #(.NUM_M(NUM_M)) u_pick (
        .req     (s_aw_valid),
        .ptr     (rr_ptr),
        .gnt_idx (pick),
        .any_req (any_req)
    );

    assign aw_sel = s_aw_pld[int'(grant) * AW_PW +: AW_PW];
    assign w_sel  = s_w_pld[int'(grant) * W_PW +: W_PW];
    assign aw_go  = (state == ADDR) && s_aw_valid[grant] && m_aw_ready;
    assign w_go   = (state == DATA) && s_w_valid[grant] && m_w_ready;
    assign w_done = w_go && w_sel[0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                grant <= pick;
            end
            if (w_done) begin
                rr_ptr <= (int'(grant) == NUM_M - 1) ? '0 : grant + 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        s_aw_ready = '0;
        s_w_ready  = '0;
        m_aw_valid = 1'b0;
        m_aw_pld   = '0;
        m_w_valid  = 1'b0;
        m_w_pld    = '0;
        unique case (state)
            IDLE: begin
                if (any_req) state_n = ADDR;
            end
            ADDR: begin
                m_aw_valid        = s_aw_valid[grant];
                m_aw_pld          = {grant, aw_sel};
                s_aw_ready[grant] = m_aw_ready;
                if (aw_go) state_n = DATA;
            end
            DATA: begin
                m_w_valid        = s_w_valid[grant];
                m_w_pld          = w_sel;
                s_w_ready[grant] = m_w_ready;
                if (w_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Response routing is independent of the AW/W state machine.
    assign b_idx   = m_b_pld[ID_W+IDX_W+1 -: IDX_W];
    assign s_b_pld = m_b_pld[ID_W+1:0];

    always_comb begin
        s_b_valid = '0;
        m_b_ready = 1'b1;
        if (int'(b_idx) < NUM_M) begin
            s_b_valid[b_idx] = m_b_valid;
            m_b_ready        = s_b_ready[b_idx];
        end
    end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
Round-robin arbiter that shares one AXI write master port (AW/W/B) between NUM_M upstream requesters in the AXI master environment.
- AW grant is held through the whole W burst, up to and including the wlast beat.
- The requester index is prepended to AWID on the way out. B responses are routed back by those upper ID bits.
- Sits between the requester agents and the single port bound to axi_mas_inf.

Parameters:
NUM_M, 4, number of requesters (2..8); IDX_W = $clog2(NUM_M) is a localparam
ID_W, 4, requester-side ID width; master-side ID width is ID_W+IDX_W
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
s_aw_valid  in  NUM_M  per-requester AWVALID
s_aw_ready  out  NUM_M  per-requester AWREADY
s_aw_pld  in  NUM_M*AW_W  per-requester packed {awid,awaddr,awlen,awsize,awburst}
s_w_valid  in  NUM_M  per-requester WVALID
s_w_ready  out  NUM_M  per-requester WREADY
s_w_pld  in  NUM_M*W_W  per-requester packed {wdata,wstrb,wlast}, wlast at bit 0
s_b_valid  out  NUM_M  per-requester BVALID
s_b_ready  in  NUM_M  per-requester BREADY
s_b_pld  out  ID_W+2  shared {bid,bresp}, valid only where s_b_valid is set
m_aw_valid  out  1  downstream AWVALID
m_aw_ready  in  1  downstream AWREADY
m_aw_pld  out  AW_W+IDX_W  AW payload with extended id
m_w_valid  out  1  downstream WVALID
m_w_ready  in  1  downstream WREADY
m_w_pld  out  W_W  W payload of granted requester
m_b_valid  in  1  downstream BVALID
m_b_ready  out  1  downstream BREADY
m_b_pld  in  ID_W+IDX_W+2  {bid,bresp}

Behaviour:
- Reset (aresetn=0, async): state=IDLE, grant=0, rr_ptr=0, all registered outputs 0. Reset mid-burst abandons the burst; there is no recovery.
- FSM has three states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_aw_valid is set, select the first set bit searching from rr_ptr upward, with wrap. Register it in grant and go to ADDR.
  - One cycle of latency from s_aw_valid to m_aw_valid.
- ADDR:
  - m_aw_valid = s_aw_valid[grant].
  - m_aw_pld = granted payload with id = {grant, awid}.
  - s_aw_ready[grant] = m_aw_ready (combinational). All other s_aw_ready bits are 0.
  - On m_aw_valid && m_aw_ready, go to DATA.
- DATA:
  - m_w_valid = s_w_valid[grant] and m_w_pld = granted W payload.
  - s_w_ready[grant] = m_w_ready. All other s_w_ready bits are 0.
  - On m_w_valid && m_w_ready && wlast: go to IDLE and set rr_ptr = (grant+1) mod NUM_M.
- W data presented by a requester before its AW is accepted is stalled (ready=0). Outside DATA, all s_w_ready are 0 and m_w_valid=0.
- awlen=0: single beat, which must carry wlast. The arbiter does not count beats; wlast alone ends the burst.
- Minimum gap between bursts is one IDLE cycle.
- Requesters must hold AWVALID once asserted, per AXI. If it drops in ADDR anyway, m_aw_valid follows it and the grant is held.
- B path is combinational and independent of the FSM, so it runs concurrently with AW/W traffic:
  - idx = m_b_pld id[ID_W+IDX_W-1:ID_W].
  - s_b_valid[idx] = m_b_valid and m_b_ready = s_b_ready[idx].
  - s_b_pld = {lower ID_W id bits, bresp}.
- If idx ≥ NUM_M (only possible when NUM_M is not a power of two): m_b_ready=1 and the response is dropped.

Decomposition:
- Package axi_wr_arb_pkg holds:
  - the aw_pld_t, w_pld_t and b_pld_t packed structs;
  - the AW_W and W_W localparams;
  - the state_e enum.
- Sub-module rr_pick (combinational round-robin priority selector) with inputs req[NUM_M] and ptr[IDX_W], and outputs gnt_idx and any_req.

Test Plan:
- Only requester 1 issues AW with awid=4'h5 and awlen=3 → m_aw_pld id=6'h15. Four W beats are forwarded, and the next AW is accepted only after the wlast handshake plus one IDLE cycle.
- All 4 requesters assert AW immediately after reset with awlen=0 → m_aw grants occur in order 0,1,2,3, then wrap to 0 if requester 0 is re-requesting.
- Requester 2 asserts wvalid before its AW is granted, while requester 0 holds the bus → s_w_ready[2]=0 throughout; its beats pass only after its own AW handshake.
- m_b_valid with bid=6'h35 and bresp=2'b10, with s_b_ready[3]=0 for 3 cycles → s_b_valid[3]=1, s_b_pld={4'h5,2'b10}, m_b_ready=0 for 3 cycles, then handshake completes.
- aresetn pulled low in DATA after 2 of 4 beats → all outputs 0 immediately. After release, requesters 0 and 3 both request and requester 0 is granted first.
- m_aw_ready held low for 5 cycles in ADDR → m_aw_valid and payload stay stable and s_aw_ready[grant] stays 0.
